// File: rtl/store_uart_bridge.sv
// Store-bus UART transmitter: bytes stored to TX_ADDR are queued in a FIFO and
// shifted out as 8N1 frames on tx without ever stalling the core.
module store_uart_bridge #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = 32'h0000_0400
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          MemWrite,
    input  logic [31:0]                   DataAdr,
    input  logic [31:0]                   WriteData,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;

    // Transmitter
    state_t            state, state_next;
    logic [BAUD_W-1:0] baud, baud_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shift, shift_next;
    logic              tx_next;
    logic              baud_last;

    logic unused_data;
    assign unused_data = ^WriteData[31:8];

    assign push_req = MemWrite && (DataAdr == TX_ADDR);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees an entry, so a push at full still lands.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count
    // define validity, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= WriteData[7:0];
    end

    assign baud_last = (baud == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;

        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud + BAUD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the next state so the pin never glitches.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_store_uart_bridge.sv
// Directed bench for store_uart_bridge with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_store_uart_bridge;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] ADDR  = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0;
    logic [31:0] write_data = '0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
        logic        exp_tx;
        int          exp_count;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [6];

    store_uart_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (ADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (mem_write),
        .DataAdr    (data_adr),
        .WriteData  (write_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of bus inputs, let one rising edge take them, and return
    // on the following falling edge where outputs are sampled.
    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        mem_write  = we;
        data_adr   = adr;
        write_data = wd;
        @(posedge clk);
        @(negedge clk);
        mem_write  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [7:0] b);
        step(1'b1, ADDR, {24'h0, b});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
    endtask

    // Check tx for frame cycles first..39, cycle 0 being the first START cycle.
    task automatic expect_frame(input logic [7:0] b, input int first);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int c = first; c < 10 * CPB; c++) begin
            check($sformatf("frame_%h_cyc%0d", b, c), {31'h0, tx}, {31'h0, bits[c / CPB]});
            idle();
        end
    endtask

    // Inter-frame idle cycle followed by the next full frame.
    task automatic expect_gap_frame(input logic [7:0] b);
        check($sformatf("gap_before_%h", b), {31'h0, tx}, 32'h1);
        idle();
        expect_frame(b, 0);
    endtask

    initial begin
        vecs[0] = '{we: 1'b1, adr: 32'h0000_03FC, data: 32'h55, exp_tx: 1'b1, exp_count: 0, exp_busy: 1'b0};
        vecs[1] = '{we: 1'b1, adr: 32'h0000_0000, data: 32'h55, exp_tx: 1'b1, exp_count: 0, exp_busy: 1'b0};
        vecs[2] = '{we: 1'b0, adr: 32'h0000_0400, data: 32'h55, exp_tx: 1'b1, exp_count: 0, exp_busy: 1'b0};
        vecs[3] = '{we: 1'b0, adr: 32'h0000_0400, data: 32'hA5, exp_tx: 1'b1, exp_count: 0, exp_busy: 1'b0};
        vecs[4] = '{we: 1'b1, adr: 32'h1000_0400, data: 32'h55, exp_tx: 1'b1, exp_count: 0, exp_busy: 1'b0};
        vecs[5] = '{we: 1'b1, adr: 32'h0000_0401, data: 32'h55, exp_tx: 1'b1, exp_count: 0, exp_busy: 1'b0};

        @(negedge clk);

        // Reset idle
        do_reset();
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_count", {29'h0, fifo_count}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            idle();
            check($sformatf("idle_tx_%0d", i), {31'h0, tx}, 32'h1);
        end

        // Address filter
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].we, vecs[i].adr, vecs[i].data);
            check($sformatf("filt%0d_tx", i), {31'h0, tx}, {31'h0, vecs[i].exp_tx});
            check($sformatf("filt%0d_count", i), {29'h0, fifo_count}, vecs[i].exp_count);
            check($sformatf("filt%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].exp_busy});
        end

        // Single byte
        step(1'b1, ADDR, 32'h0000_00A5);
        check("single_count_k", {29'h0, fifo_count}, 32'h1);
        check("single_tx_k", {31'h0, tx}, 32'h1);
        check("single_busy_k", {31'h0, busy}, 32'h1);
        idle();
        check("single_count_k1", {29'h0, fifo_count}, 32'h0);
        expect_frame(8'hA5, 0);
        check("single_busy_end", {31'h0, busy}, 32'h0);
        check("single_tx_end", {31'h0, tx}, 32'h1);

        // Overflow
        for (int i = 1; i <= 6; i++) store(8'(i));
        check("ovf_count", {29'h0, fifo_count}, 32'h4);
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        expect_frame(8'h01, 4);
        expect_gap_frame(8'h02);
        expect_gap_frame(8'h03);
        expect_gap_frame(8'h04);
        expect_gap_frame(8'h05);
        check("ovf_drain_busy", {31'h0, busy}, 32'h0);
        check("ovf_drain_count", {29'h0, fifo_count}, 32'h0);
        for (int i = 0; i < 10; i++) idle();
        check("ovf_sticky", {31'h0, overflow}, 32'h1);
        check("ovf_no_sixth_tx", {31'h0, tx}, 32'h1);

        // Simultaneous push/pop at full
        do_reset();
        check("pp_rst_overflow", {31'h0, overflow}, 32'h0);
        store(8'h11);
        store(8'h22);
        store(8'h33);
        store(8'h44);
        store(8'h55);
        check("pp_full_count", {29'h0, fifo_count}, 32'h4);
        expect_frame(8'h11, 3);
        check("pp_idle_tx", {31'h0, tx}, 32'h1);
        check("pp_idle_count", {29'h0, fifo_count}, 32'h4);
        store(8'h77);
        check("pp_count_after", {29'h0, fifo_count}, 32'h4);
        check("pp_overflow", {31'h0, overflow}, 32'h0);
        expect_frame(8'h22, 0);
        expect_gap_frame(8'h33);
        expect_gap_frame(8'h44);
        expect_gap_frame(8'h55);
        expect_gap_frame(8'h77);
        check("pp_drain_busy", {31'h0, busy}, 32'h0);
        check("pp_overflow_end", {31'h0, overflow}, 32'h0);

        // Reset mid-frame during DATA bit 3 of F0 with two bytes queued
        store(8'hF0);
        store(8'hAA);
        store(8'hBB);
        check("mid_count", {29'h0, fifo_count}, 32'h2);
        for (int i = 0; i < 16; i++) idle();
        check("mid_bit3_tx", {31'h0, tx}, 32'h0);
        check("mid_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        idle();
        check("mid_rst_tx", {31'h0, tx}, 32'h1);
        check("mid_rst_count", {29'h0, fifo_count}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            idle();
            check($sformatf("mid_quiet_tx_%0d", i), {31'h0, tx}, 32'h1);
        end
        check("mid_quiet_busy", {31'h0, busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_uart_bridge.md
Name: store_uart_bridge

Overview:
- Memory-mapped UART transmit peripheral, directly downstream of the processor top level.
- Snoops the store bus (MemWrite, DataAdr, WriteData) that the top level drives.
- Captures the byte stored to one fixed address into a FIFO and serializes it as 8N1 on a TX pin.
- Gives the single-cycle ARM core a debug/console output without stalling the core.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, byte entries; power of two, 2..256.
- TX_ADDR, 32'h0000_0400, full 32-bit store address that enqueues a byte.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  store strobe from the core.
- DataAdr  in  32  store address from the core.
- WriteData  in  32  store data from the core; only bits [7:0] are used.
- tx  out  1  UART serial output; idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte currently being shifted.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset: synchronous and active-high, sampled on the clk rising edge.
  - Outputs: tx=1, busy=0, fifo_count=0, overflow=0.
  - FIFO pointers, FSM state, bit and baud counters are cleared.
  - Reset mid-frame aborts the frame; tx=1 after that edge.
- Capture: push = MemWrite && (DataAdr == TX_ADDR), full 32-bit compare.
  - WriteData[7:0] is written on the same edge the data memory writes.
  - Stores to any other address are ignored.
  - Loads have no effect; this block is write-only.
- Full FIFO: a push with count==FIFO_DEPTH and no pop that cycle is dropped and overflow<=1.
  - overflow stays set until reset.
- Push and pop in the same cycle: both take effect and count is unchanged.
  - When full, the push is accepted because the pop frees an entry.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first). Each bit is held CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - One frame = 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 1 IDLE cycle with tx=1.
  - Latency: a store accepted at edge k gives fifo_count=1 after edge k. IDLE pops at edge k+1, so tx=0 and fifo_count=0 after edge k+1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width $clog2(CLKS_PER_BIT).
- FIFO pointers: wrap modulo FIFO_DEPTH. fifo_count is computed from a separate up/down counter, never from pointer difference alone.
- busy = (state != IDLE) || (fifo_count != 0); registered-equivalent, no glitch on tx.
- tx is driven from a flop.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset idle: assert reset for 2 cycles → tx=1, busy=0, fifo_count=0, overflow=0. Hold for 20 cycles → tx stays 1.
- Single byte: store 32'h0000_00A5 to 32'h400 at edge k.
  - fifo_count=1 after edge k; tx=0 from edge k+1 for 4 cycles.
  - Then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop bit 1.
  - busy falls 40 cycles after edge k+1.
- Address filter: store 8'h55 to 32'h3FC and 32'h0000_0000, and load-like cycles with MemWrite=0 at 32'h400 → fifo_count stays 0, tx stays 1.
- Overflow: 6 consecutive stores 8'h01..8'h06 to 32'h400 on cycles k..k+5.
  - First byte popped at k+1, so 4 queued plus 1 shifting.
  - Byte 8'h06 is dropped and overflow=1.
  - Serial output is 01,02,03,04,05 with 1 idle cycle between frames.
  - overflow remains 1 after all frames drain.
- Simultaneous push/pop at full: fill FIFO to 4 during a frame; store 8'h77 on the cycle IDLE pops → accepted, fifo_count stays 4, overflow=0, and 8'h77 is transmitted last.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hF0 with 2 bytes queued.
  - tx=1 after that edge; fifo_count=0 and busy=0.
  - No further frames are sent after reset deasserts.
